// File: rtl/mdu_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divider_pkg
// Purpose  : Shared types and constants for the RV32M divide unit:
//            - the divider FSM state type;
//            - the funct3 encodings and their decode bit positions.
// Revision : 1.0  initial release
// ============================================================================

// Core-wide operand width and M-extension funct3 encodings.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef DIV_FUNC
`define DIV_FUNC  3'b100
`endif
`ifndef DIVU_FUNC
`define DIVU_FUNC 3'b101
`endif
`ifndef REM_FUNC
`define REM_FUNC  3'b110
`endif
`ifndef REMU_FUNC
`define REMU_FUNC 3'b111
`endif
// The divider retires one quotient bit per cycle.
`ifndef DIV_ITERS
`define DIV_ITERS `DATA_SIZE
`endif

package mdu_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // funct3 bit positions.
  // Bit 1 picks the remainder, bit 0 picks unsigned arithmetic.
  // Bit 2 only separates the divide group from multiply and is not decoded here.
  localparam int unsigned FUNC_REM_BIT = 1;
  localparam int unsigned FUNC_UNS_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divider
// Purpose  : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//            - Works on operand magnitudes and applies signs in a final FIX
//              step.
//            - Divide-by-zero and signed overflow complete in one cycle.
// Revision : 1.0  initial release
// ============================================================================
module mdu_divider
  import mdu_divider_pkg::*;
#(
  parameter int DATA_W = `DATA_SIZE,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        func_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;       // partial remainder (magnitude)
  logic [DATA_W-1:0] quo_q, quo_d;       // dividend shifting out / quotient shifting in
  logic [DATA_W-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic              negq_q, negq_d;     // quotient must be negated in FIX
  logic              negr_q, negr_d;     // remainder must be negated in FIX
  logic              selr_q, selr_d;     // op returns the remainder
  logic [DATA_W-1:0] result_q, result_d;

  // funct3 bit 2 is irrelevant once the op has been routed here.
  logic unused_func_bit2;
  assign unused_func_bit2 = func_i[2];

  // Request decode and operand magnitudes, only meaningful at accept.
  logic              op_signed;
  logic              op_rem;
  logic [DATA_W-1:0] rs1_mag;
  logic [DATA_W-1:0] rs2_mag;
  logic              div_by_zero;
  logic              sgn_overflow;

  assign op_signed    = ~func_i[FUNC_UNS_BIT];
  assign op_rem       = func_i[FUNC_REM_BIT];
  assign rs1_mag      = (op_signed && rs1_i[DATA_W-1]) ? -rs1_i : rs1_i;
  assign rs2_mag      = (op_signed && rs2_i[DATA_W-1]) ? -rs2_i : rs2_i;
  assign div_by_zero  = (rs2_i == '0);
  assign sgn_overflow = op_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract the divisor one bit wider so the borrow is visible.
  logic [DATA_W:0] step_shift;
  logic [DATA_W:0] step_trial;

  assign step_shift = {rem_q, quo_q[DATA_W-1]};
  assign step_trial = step_shift - {1'b0, dvs_q};

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      selr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      selr_q   <= selr_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update; a flush freezes the datapath and returns to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    selr_d   = selr_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          selr_d = op_rem;
          if (div_by_zero) begin
            result_d = op_rem ? rs1_i : '1;
            state_d  = DONE;
          end else if (sgn_overflow) begin
            result_d = op_rem ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = rs1_mag;
            dvs_d   = rs2_mag;
            negq_d  = op_signed && (rs1_i[DATA_W-1] ^ rs2_i[DATA_W-1]);
            negr_d  = op_signed && rs1_i[DATA_W-1];
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!step_trial[DATA_W]) begin
          rem_d = step_trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = step_shift[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (selr_q) begin
          result_d = negr_q ? -rem_q : rem_q;
        end else begin
          result_d = negq_q ? -quo_q : quo_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      selr_d   = selr_q;
      result_d = result_q;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

`default_nettype wire
